fetch_queue: RTL and testbench

- Decoupling buffer between the instruction-fetch stage and the decode stage.
- Captures {pc, pc_plus4, instruction} tuples from fetch into a small circular FIFO and presents the oldest entry to decode over a valid/ready handshake.
- Back-pressure is exported to fetch as a stall, and a redirect flush discards all queued wrong-path instructions.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO of {pc, pc_plus4, instruction} tuples with flush.
// Optional performance counters are compiled in with FETCH_QUEUE_PERF_EN.
module fetch_queue #(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_pc_plus4,
    input  logic [XLEN-1:0]        in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_plus4,
    output logic [XLEN-1:0]        out_instr,
    output logic                   fetch_stall,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]            perf_full_cycles,
    output logic [31:0]            perf_empty_cycles,
    output logic [31:0]            perf_flushes
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] pc4_mem   [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic            push;
    logic            pop;

    // Handshake flags are pure functions of the registered occupancy.
    assign in_ready    = (count != CW'(DEPTH));
    assign fetch_stall = ~in_ready;
    assign out_valid   = (count != '0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    // Head read; an empty queue presents a canonical NOP rather than stale data.
    always_comb begin
        out_pc       = '0;
        out_pc_plus4 = '0;
        out_instr    = NOP_INSTR;
        if (out_valid) begin
            out_pc       = pc_mem[rd_ptr];
            out_pc_plus4 = pc4_mem[rd_ptr];
            out_instr    = instr_mem[rd_ptr];
        end
    end

    // Entry storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            pc4_mem[wr_ptr]   <= in_pc_plus4;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    // Free-running event counters; wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_full_cycles  <= '0;
            perf_empty_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (in_valid && !in_ready)  perf_full_cycles  <= perf_full_cycles + 32'(1);
            if (!out_valid && out_ready) perf_empty_cycles <= perf_empty_cycles + 32'(1);
            if (flush)                   perf_flushes      <= perf_flushes + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: stimulus table plus scoreboard of queued tuples.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, fetch_stall;
    logic [31:0] in_pc, in_pc_plus4, in_instr, out_pc, out_pc_plus4, out_instr;
    logic [2:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_full_cycles, perf_empty_cycles, perf_flushes;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_pc_plus4  (in_pc_plus4),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .fetch_stall  (fetch_stall),
        .count        (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        int          exp_count;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    vec_t        vecs[$];
    ent_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned m_full   = 0;
    int unsigned m_empty  = 0;
    int unsigned m_flush  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA5C0_0033 ^ {pc[19:0], 12'h000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, input int c);
        vec_t e;
        e.v = v; e.pc = pc; e.rdy = rdy; e.fl = fl; e.exp_count = c;
        vecs.push_back(e);
    endtask

    // One clock: drive, check head against scoreboard, update model, check after edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input int exp_count, input string tag);
        bit   do_push, do_pop;
        ent_t e;
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus4 = pc + 32'd4;
        in_instr    = instr_of(pc);
        out_ready   = rdy;
        flush       = fl;
        #1;
        chk({tag, "_in_ready"},    32'(in_ready),    32'(sb.size() != DEPTH));
        chk({tag, "_fetch_stall"}, 32'(fetch_stall), 32'(sb.size() == DEPTH));
        chk({tag, "_out_valid"},   32'(out_valid),   32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({tag, "_out_pc"},    out_pc,       sb[0].pc);
            chk({tag, "_out_pc4"},   out_pc_plus4, sb[0].pc4);
            chk({tag, "_out_instr"}, out_instr,    sb[0].instr);
        end else begin
            chk({tag, "_empty_pc"},    out_pc,    32'h0);
            chk({tag, "_empty_instr"}, out_instr, NOP);
        end
        do_push = v && (sb.size() != DEPTH);
        do_pop  = rdy && (sb.size() != 0);
        if (v && sb.size() == DEPTH) m_full++;
        if (rdy && sb.size() == 0)   m_empty++;
        if (fl)                      m_flush++;
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.pc = pc; e.pc4 = pc + 32'd4; e.instr = instr_of(pc);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_count_model"}, 32'(count), 32'(sb.size()));
        if (exp_count >= 0) chk({tag, "_count_table"}, 32'(count), 32'(exp_count));
`ifdef FETCH_QUEUE_PERF_EN
        chk({tag, "_perf_full"},  perf_full_cycles,  m_full);
        chk({tag, "_perf_empty"}, perf_empty_cycles, m_empty);
        chk({tag, "_perf_flush"}, perf_flushes,      m_flush);
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_pc_plus4 = '0; in_instr = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_count",     32'(count),       32'd0);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_stall",     32'(fetch_stall), 32'd0);
        chk("rst_out_pc",    out_pc,           32'h0);
        chk("rst_out_pc4",   out_pc_plus4,     32'h0);
        chk("rst_out_instr", out_instr,        NOP);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, fill to full, refuse fifth push, drain through full boundary.
        add(0, 32'h0, 1, 0, 0);
        add(0, 32'h0, 1, 0, 0);
        add(1, 32'h0, 0, 0, 1);
        add(1, 32'h4, 0, 0, 2);
        add(1, 32'h8, 0, 0, 3);
        add(1, 32'hC, 0, 0, 4);
        add(1, 32'h10, 0, 0, 4);
        add(1, 32'h10, 1, 0, 3);
        add(1, 32'h10, 1, 0, 3);
        add(0, 32'h0, 1, 0, 2);
        add(0, 32'h0, 1, 0, 1);
        add(0, 32'h0, 1, 0, 0);
        // Flush with a coincident push, then a fresh path.
        add(1, 32'h40, 0, 0, 1);
        add(1, 32'h44, 0, 0, 2);
        add(1, 32'h48, 0, 0, 3);
        add(1, 32'h20, 0, 1, 0);
        add(1, 32'h100, 0, 0, 1);
        add(0, 32'h0, 0, 0, 1);
        add(0, 32'h0, 1, 0, 0);
        // Streaming at occupancy 1 across several pointer wraps.
        add(1, 32'h200, 0, 0, 1);
        for (int i = 1; i <= 10; i++) add(1, 32'h200 + 32'(4 * i), 1, 0, 1);
        add(0, 32'h0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].fl, vecs[i].exp_count,
                 $sformatf("v%0d", i));

        // Asynchronous reset in the middle of a clock phase.
        step(1, 32'h300, 0, 0, 1, "ar0");
        step(1, 32'h304, 0, 0, 2, "ar1");
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_full = 0; m_empty = 0; m_flush = 0;
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_instr", out_instr,      NOP);
`ifdef FETCH_QUEUE_PERF_EN
        chk("arst_perf_full",  perf_full_cycles,  32'd0);
        chk("arst_perf_empty", perf_empty_cycles, 32'd0);
        chk("arst_perf_flush", perf_flushes,      32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h400, 0, 0, 1, "post_rst");
        step(0, 32'h0, 1, 0, 0, "post_rst_pop");

`ifdef FETCH_QUEUE_PERF_EN
        // Hold full against fetch for five cycles, then two flushes.
        for (int i = 0; i < 4; i++) step(1, 32'h500 + 32'(4 * i), 0, 0, i + 1, $sformatf("pf_fill%0d", i));
        for (int i = 0; i < 5; i++) step(1, 32'h510, 0, 0, 4, $sformatf("pf_hold%0d", i));
        chk("pf_full_total", perf_full_cycles, 32'd5);
        step(0, 32'h0, 0, 1, 0, "pf_flush0");
        step(0, 32'h0, 0, 1, 0, "pf_flush1");
        chk("pf_flush_total", perf_flushes, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
